// File: rtl/seq_div.sv
// Signed 16/8 sequential divider: bit-serial restoring core on magnitudes, one
// quotient bit per cycle, fixed 9-edge latency from start to the done pulse.
module seq_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [7:0]  quot,
    output logic [7:0]  rem,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    // start is a single-cycle request with no ready: it is taken only when
    // busy=0 (IDLE); any start seen while busy=1 is dropped, operands unchanged.
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [7:0]  part_rem;
    logic [7:0]  quo_sr;
    logic [7:0]  dvs_mag;
    logic        sign_dd;
    logic        sign_dv;
    logic        pre_ovf;

    logic [15:0] dd_mag;
    logic [7:0]  dv_mag;
    logic [8:0]  trial;
    logic [8:0]  diff;
    logic        neg_q;
    logic        range_ovf;
    logic        any_ovf;

    assign dd_mag = dividend[15] ? (~dividend + 16'd1) : dividend;
    assign dv_mag = divisor[7]   ? (~divisor  + 8'd1)  : divisor;

    // Partial remainder stays below |divisor| <= 128 when no pre-overflow, so
    // shifting in one dividend bit never exceeds 9 bits.
    assign trial = {part_rem, quo_sr[7]};
    assign diff  = trial - {1'b0, dvs_mag};

    assign neg_q     = sign_dd ^ sign_dv;
    assign range_ovf = neg_q ? (quo_sr > 8'd128) : quo_sr[7];
    assign any_ovf   = pre_ovf | range_ovf;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 4'd7) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            part_rem <= 8'd0;
            quo_sr   <= 8'd0;
            dvs_mag  <= 8'd0;
            sign_dd  <= 1'b0;
            sign_dv  <= 1'b0;
            pre_ovf  <= 1'b0;
            quot     <= 8'd0;
            rem      <= 8'd0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= 4'd0;
                        part_rem <= dd_mag[15:8];
                        quo_sr   <= dd_mag[7:0];
                        dvs_mag  <= dv_mag;
                        sign_dd  <= dividend[15];
                        sign_dv  <= divisor[7];
                        // Also catches divide-by-zero: any upper byte is >= 0.
                        pre_ovf  <= (dd_mag[15:8] >= dv_mag);
                    end
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    if (!diff[8]) begin
                        part_rem <= diff[7:0];
                        quo_sr   <= {quo_sr[6:0], 1'b1};
                    end else begin
                        part_rem <= trial[7:0];
                        quo_sr   <= {quo_sr[6:0], 1'b0};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    ovf  <= any_ovf;
                    if (any_ovf) begin
                        quot <= 8'd0;
                        rem  <= 8'd0;
                    end else begin
                        quot <= neg_q   ? (~quo_sr   + 8'd1) : quo_sr;
                        rem  <= sign_dd ? (~part_rem + 8'd1) : part_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: hand-computed quotient/remainder/overflow vectors,
// latency, back-to-back starts, ignored mid-flight start and reset abort.
module tb_seq_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        ovf;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    seq_div dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quot     (quot),
        .rem      (rem),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one division from a negedge and checks result, latency and busy
    // duration. With poke=1 a foreign start is pulsed mid-CALC.
    task automatic run_div(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                           input logic [7:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_ovf, input bit poke);
        int lat;
        int busy_cnt;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            if (poke && lat == 3) begin
                start    = 1'b1;
                dividend = 16'd1000;
                divisor  = 8'd3;
            end else if (poke && lat == 4) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, ".lat"},  lat, 9);
        check({tag, ".busy"}, busy_cnt, 9);
        check({tag, ".quot"}, quot, exp_q);
        check({tag, ".rem"},  rem, exp_r);
        check({tag, ".ovf"},  ovf, exp_ovf);
        @(posedge clk);
        #1;
        check({tag, ".hold"}, {done, ovf, quot, rem}, {1'b0, exp_ovf, exp_q, exp_r});
    endtask

    task automatic back_to_back();
        int n_done;
        int first_at;
        int second_at;
        n_done    = 0;
        first_at  = -1;
        second_at = -1;
        @(negedge clk);
        dividend = 16'd390;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (first_at < 0) first_at = e;
                else second_at = e;
            end
        end
        start = 1'b0;
        check("b2b.count",  n_done, 2);
        check("b2b.first",  first_at, 9);
        check("b2b.second", second_at, 19);
        check("b2b.quot",   {ovf, quot, rem}, {1'b0, 8'd30, 8'd0});
        @(posedge clk);
        #1;
        check("b2b.idle", {busy, done}, 2'b00);
    endtask

    task automatic reset_abort();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        dividend = 16'd390;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst.outs", {busy, done, ovf, quot, rem}, 19'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("rst.no_done", seen_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("rst.after", 16'hFE7A, 8'd13, 8'hE2, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        #12;
        check("reset", {busy, done, ovf, quot, rem}, 19'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("390/13",      16'd390,  8'd13,   8'd30,  8'd0,  1'b0, 1'b0);
        run_div("-100/7",      16'hFF9C, 8'd7,    8'hF2,  8'hFE, 1'b0, 1'b0);
        run_div("100/-7",      16'd100,  8'hF9,   8'hF2,  8'h02, 1'b0, 1'b0);
        run_div("1234/0",      16'd1234, 8'd0,    8'h00,  8'h00, 1'b1, 1'b0);
        run_div("128/1",       16'd128,  8'd1,    8'h00,  8'h00, 1'b1, 1'b0);
        run_div("-128/1",      16'hFF80, 8'd1,    8'h80,  8'h00, 1'b0, 1'b0);
        run_div("-32768/-128", 16'h8000, 8'h80,   8'h00,  8'h00, 1'b1, 1'b0);
        run_div("-16384/-128", 16'hC000, 8'h80,   8'h00,  8'h00, 1'b1, 1'b0);
        run_div("16256/127",   16'd16256, 8'd127, 8'h00,  8'h00, 1'b1, 1'b0);
        run_div("16255/127",   16'd16255, 8'd127, 8'h7F,  8'h7E, 1'b0, 1'b0);
        run_div("-1000/-9",    16'hFC18, 8'hF7,   8'h6F,  8'hFF, 1'b0, 1'b0);
        run_div("127/-128",    16'd127,  8'h80,   8'h00,  8'h7F, 1'b0, 1'b0);
        run_div("32767/-128",  16'h7FFF, 8'h80,   8'h00,  8'h00, 1'b1, 1'b0);
        run_div("poke",        16'd390,  8'd13,   8'd30,  8'd0,  1'b0, 1'b1);
        back_to_back();
        reset_abort();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
